// File: rtl/excp_cp0_unit_pkg.sv
// Shared CP0 addresses, resolved exception codes, ExcCode values and Status/Cause bit positions.
package excp_cp0_unit_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam logic [4:0] CP0_PRID    = 5'd15;
    localparam logic [4:0] CP0_CONFIG  = 5'd16;

    localparam logic [31:0] EXC_NONE         = 32'h0;
    localparam logic [31:0] EXC_INT          = 32'h1;
    localparam logic [31:0] EXC_SYSCALL      = 32'h8;
    localparam logic [31:0] EXC_INST_INVALID = 32'ha;
    localparam logic [31:0] EXC_TRAP         = 32'hd;
    localparam logic [31:0] EXC_OV           = 32'hc;
    localparam logic [31:0] EXC_ERET         = 32'he;

    localparam logic [4:0] EXCCODE_INT = 5'h00;
    localparam logic [4:0] EXCCODE_SYS = 5'h08;
    localparam logic [4:0] EXCCODE_RI  = 5'h0a;
    localparam logic [4:0] EXCCODE_TR  = 5'h0d;
    localparam logic [4:0] EXCCODE_OV  = 5'h0c;

    // Raw flag positions in the MEM-stage excepttype word.
    localparam int FLAG_SYSCALL      = 8;
    localparam int FLAG_INST_INVALID = 9;
    localparam int FLAG_TRAP         = 10;
    localparam int FLAG_OV           = 11;
    localparam int FLAG_ERET         = 12;

    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_IM_LO = 8;
    localparam int STATUS_IM_HI = 15;

    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 8;
    localparam int CAUSE_SW_HI  = 9;
    localparam int CAUSE_HW_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_WP     = 22;
    localparam int CAUSE_IV     = 23;
    localparam int CAUSE_BD     = 31;

    function automatic logic is_entry(input logic [31:0] code);
        return (code == EXC_INT) || (code == EXC_SYSCALL) || (code == EXC_INST_INVALID) ||
               (code == EXC_TRAP) || (code == EXC_OV);
    endfunction

    function automatic logic [4:0] exccode_of(input logic [31:0] code);
        logic [4:0] ec;
        ec = EXCCODE_INT;
        case (code)
            EXC_SYSCALL:      ec = EXCCODE_SYS;
            EXC_INST_INVALID: ec = EXCCODE_RI;
            EXC_TRAP:         ec = EXCCODE_TR;
            EXC_OV:           ec = EXCCODE_OV;
            default:          ec = EXCCODE_INT;
        endcase
        return ec;
    endfunction

endpackage

// File: rtl/excp_cp0_unit_timer.sv
// CP0 Count/Compare pair and the timer interrupt flop.
module cp0_timer
    import excp_cp0_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int
);

    logic count_we;
    logic compare_we;

    assign count_we   = we && (waddr == CP0_COUNT);
    assign compare_we = we && (waddr == CP0_COMPARE);

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= '0;
            compare   <= '0;
            timer_int <= 1'b0;
        end else begin
            count <= count_we ? wdata : count + 32'd1;
            // A Compare write acknowledges the timer, and wins over a same-cycle match.
            if (compare_we) begin
                compare   <= wdata;
                timer_int <= 1'b0;
            end else if ((compare != '0) && (count == compare)) begin
                timer_int <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/excp_cp0_unit.sv
// MEM-stage exception resolver and CP0 register file (Status/Cause/EPC plus timer).
module excp_cp0_unit
    import excp_cp0_unit_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE   = 32'h00480102,
    parameter logic [31:0] CONFIG_VALUE = 32'h00008000,
    parameter logic [31:0] STATUS_RESET = 32'h10000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_address_i,
    input  logic        is_in_delayslot_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] data_o,
    output logic [31:0] excepttype_o,
    output logic [31:0] cp0_epc_o,
    output logic        timer_int_o
);

    logic [31:0] status_q, cause_q, epc_q;
    logic [31:0] status_f, cause_f, epc_f;
    logic [31:0] count, compare;
    logic [31:0] exc_type;
    logic        int_pending;
    logic        unused_flags;

    cp0_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .we        (wb_cp0_we_i),
        .waddr     (wb_cp0_waddr_i),
        .wdata     (wb_cp0_data_i),
        .count     (count),
        .compare   (compare),
        .timer_int (timer_int_o)
    );

    assign unused_flags = ^{excepttype_i[31:13], excepttype_i[7:0]};

    // The older WB instruction's CP0 write is visible to the MEM-stage decision in the same cycle.
    assign status_f = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_STATUS) ? wb_cp0_data_i : status_q;
    assign cause_f  = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_CAUSE)  ? wb_cp0_data_i : cause_q;
    assign epc_f    = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_EPC)    ? wb_cp0_data_i : epc_q;

    assign int_pending = ((cause_f[CAUSE_IP_HI:CAUSE_IP_LO] & status_f[STATUS_IM_HI:STATUS_IM_LO]) != '0)
                         && !status_f[STATUS_EXL] && status_f[STATUS_IE];

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        exc_type = EXC_NONE;
        if (current_inst_address_i != '0) begin
            if (int_pending)                            exc_type = EXC_INT;
            else if (excepttype_i[FLAG_SYSCALL])        exc_type = EXC_SYSCALL;
            else if (excepttype_i[FLAG_INST_INVALID])   exc_type = EXC_INST_INVALID;
            else if (excepttype_i[FLAG_TRAP])           exc_type = EXC_TRAP;
            else if (excepttype_i[FLAG_OV])             exc_type = EXC_OV;
            else if (excepttype_i[FLAG_ERET])           exc_type = EXC_ERET;
        end
    end

    assign excepttype_o = rst ? exc_type : EXC_NONE;
    assign cp0_epc_o    = rst ? epc_f    : '0;

    always_comb begin
        data_o = '0;
        case (raddr_i)
            CP0_COUNT:   data_o = count;
            CP0_COMPARE: data_o = compare;
            CP0_STATUS:  data_o = status_f;
            CP0_CAUSE:   data_o = cause_f;
            CP0_EPC:     data_o = epc_f;
            CP0_PRID:    data_o = PRID_VALUE;
            CP0_CONFIG:  data_o = CONFIG_VALUE;
            default:     data_o = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_q <= STATUS_RESET;
            cause_q  <= '0;
            epc_q    <= '0;
        end else begin
            cause_q[CAUSE_IP_HI:CAUSE_HW_LO] <= int_i;
            if (wb_cp0_we_i) begin
                case (wb_cp0_waddr_i)
                    CP0_STATUS: status_q <= wb_cp0_data_i;
                    CP0_CAUSE: begin
                        cause_q[CAUSE_SW_HI:CAUSE_IP_LO] <= wb_cp0_data_i[CAUSE_SW_HI:CAUSE_IP_LO];
                        cause_q[CAUSE_IV]                <= wb_cp0_data_i[CAUSE_IV];
                        cause_q[CAUSE_WP]                <= wb_cp0_data_i[CAUSE_WP];
                    end
                    CP0_EPC:    epc_q <= wb_cp0_data_i;
                    default:    ;
                endcase
            end
            // Later non-blocking assignments override the WB write on the bits they share.
            if (is_entry(exc_type)) begin
                if (!status_f[STATUS_EXL]) begin
                    epc_q             <= is_in_delayslot_i ? current_inst_address_i - 32'd4
                                                           : current_inst_address_i;
                    cause_q[CAUSE_BD] <= is_in_delayslot_i;
                end
                status_q[STATUS_EXL]                 <= 1'b1;
                cause_q[CAUSE_EXC_HI:CAUSE_EXC_LO]   <= exccode_of(exc_type);
            end else if (exc_type == EXC_ERET) begin
                status_q[STATUS_EXL] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_excp_cp0_unit.sv
// Directed self-checking bench for excp_cp0_unit with hand-computed expectations.
module tb_excp_cp0_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i;
    logic [31:0] current_inst_address_i;
    logic        is_in_delayslot_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_data_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_o;
    logic [31:0] excepttype_o;
    logic [31:0] cp0_epc_o;
    logic        timer_int_o;

    int total = 0;
    int bad   = 0;

    excp_cp0_unit dut (
        .clk                    (clk),
        .rst                    (rst),
        .int_i                  (int_i),
        .excepttype_i           (excepttype_i),
        .current_inst_address_i (current_inst_address_i),
        .is_in_delayslot_i      (is_in_delayslot_i),
        .wb_cp0_we_i            (wb_cp0_we_i),
        .wb_cp0_waddr_i         (wb_cp0_waddr_i),
        .wb_cp0_data_i          (wb_cp0_data_i),
        .raddr_i                (raddr_i),
        .data_o                 (data_o),
        .excepttype_o           (excepttype_o),
        .cp0_epc_o              (cp0_epc_o),
        .timer_int_o            (timer_int_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        raddr_i = a;
        #1;
        check(tag, data_o, exp);
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = a; wb_cp0_data_i = d;
        step();
        wb_cp0_we_i = 1'b0;
    endtask

    task automatic mem(input logic [31:0] flags, input logic [31:0] pc, input logic ds);
        excepttype_i = flags; current_inst_address_i = pc; is_in_delayslot_i = ds;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; int_i = '0; excepttype_i = '0; current_inst_address_i = '0;
        is_in_delayslot_i = 1'b0; wb_cp0_we_i = 1'b0; wb_cp0_waddr_i = '0;
        wb_cp0_data_i = '0; raddr_i = '0;
        #12;
        rd("rst_status", 5'd12, 32'h10000000);
        rd("rst_cause", 5'd13, 32'h0);
        check("rst_exc", excepttype_o, 32'h0);
        check("rst_timer", {31'b0, timer_int_o}, 32'h0);
        #1 rst = 1'b1;

        // Syscall in a delay slot.
        mem(32'h100, 32'h104, 1'b1);
        check("sys_type", excepttype_o, 32'h8);
        step();
        mem(32'h0, 32'h0, 1'b0);
        rd("sys_epc", 5'd14, 32'h100);
        rd("sys_cause", 5'd13, 32'h80000020);
        rd("sys_status", 5'd12, 32'h10000002);

        // ERET with a same-cycle WB write of EPC.
        wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'h3000;
        mem(32'h1000, 32'h108, 1'b0);
        check("eret_type", excepttype_o, 32'he);
        check("eret_epc_fwd", cp0_epc_o, 32'h3000);
        step();
        wb_cp0_we_i = 1'b0;
        mem(32'h0, 32'h0, 1'b0);
        rd("eret_status", 5'd12, 32'h10000000);
        rd("eret_epc", 5'd14, 32'h3000);

        // Priority among raw flags (combinational only, no edge taken).
        mem(32'hA00, 32'h300, 1'b0);  check("prio_9_11", excepttype_o, 32'ha);
        mem(32'hB00, 32'h300, 1'b0);  check("prio_8_9_11", excepttype_o, 32'h8);
        mem(32'h400, 32'h300, 1'b0);  check("prio_trap", excepttype_o, 32'hd);
        mem(32'h800, 32'h300, 1'b0);  check("prio_ov", excepttype_o, 32'hc);
        mem(32'h0, 32'h300, 1'b0);    check("prio_none", excepttype_o, 32'h0);
        mem(32'h100, 32'h0, 1'b0);    check("bubble", excepttype_o, 32'h0);
        mem(32'h0, 32'h0, 1'b0);

        // Interrupt gating: IM2 + IE, int_i[0] lands in Cause.IP2 after one clock.
        wb_write(5'd12, 32'h00000401);
        int_i = 6'b000001;
        step();
        rd("int_cause_ip", 5'd13, 32'h80000420);
        check("int_bubble", excepttype_o, 32'h0);
        mem(32'h0, 32'h200, 1'b0);
        check("int_type", excepttype_o, 32'h1);
        step();
        mem(32'h0, 32'h204, 1'b0);
        check("int_exl_masked", excepttype_o, 32'h0);
        rd("int_epc", 5'd14, 32'h200);
        rd("int_cause", 5'd13, 32'h00000400);
        rd("int_status", 5'd12, 32'h00000403);

        // Nested syscall keeps EPC and BD.
        mem(32'h100, 32'h500, 1'b1);
        check("nest_type", excepttype_o, 32'h8);
        step();
        mem(32'h0, 32'h0, 1'b0);
        rd("nest_epc", 5'd14, 32'h200);
        rd("nest_cause", 5'd13, 32'h00000420);

        // Only IP[1:0], IV and WP are software writable.
        wb_write(5'd13, 32'hFFFFFFFF);
        rd("cause_wmask", 5'd13, 32'h00C00720);
        int_i = '0;

        rd("prid", 5'd15, 32'h00480102);
        rd("config", 5'd16, 32'h00008000);
        rd("unknown", 5'd5, 32'h0);
        wb_write(5'd15, 32'h0);
        rd("prid_ro", 5'd15, 32'h00480102);

        // Timer.
        wb_write(5'd11, 32'd5);
        wb_write(5'd9, 32'd3);
        rd("tmr_count3", 5'd9, 32'd3);
        step();
        step();
        rd("tmr_count5", 5'd9, 32'd5);
        check("tmr_not_yet", {31'b0, timer_int_o}, 32'h0);
        step();
        check("tmr_set", {31'b0, timer_int_o}, 32'h1);
        rd("tmr_count6", 5'd9, 32'd6);
        wb_write(5'd11, 32'h100);
        check("tmr_clear", {31'b0, timer_int_o}, 32'h0);

        // Asynchronous reset mid-run.
        wb_write(5'd9, 32'h1234);
        rd("pre_rst_count", 5'd9, 32'h1234);
        mem(32'h100, 32'h400, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("mr_exc", excepttype_o, 32'h0);
        check("mr_epc_o", cp0_epc_o, 32'h0);
        rd("mr_count", 5'd9, 32'h0);
        rd("mr_status", 5'd12, 32'h10000000);
        rd("mr_cause", 5'd13, 32'h0);
        rd("mr_epc", 5'd14, 32'h0);
        rd("mr_compare", 5'd11, 32'h0);
        step();
        rd("mr_count_held", 5'd9, 32'h0);
        mem(32'h0, 32'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/excp_cp0_unit.md
Name: excp_cp0_unit

Overview:
- Memory-stage exception resolver with CP0 register file; sits between the MEM stage and the pipeline controller.
- Merges raw exception flags from the pipeline with pending hardware/timer interrupts and picks one.
- Drives the exception-type code and the forwarded EPC to the controller, which turns them into flush and a new PC.
- Owns Count/Compare/Status/Cause/EPC state, updated on exception entry, ERET and CP0 writes from WB.

Parameters:
- PRID_VALUE, 32'h00480102, read-only PRId contents.
- CONFIG_VALUE, 32'h00008000, read-only Config contents (big-endian flag).
- STATUS_RESET, 32'h10000000, Status value after reset (CU0=1, IE=0, EXL=0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- int_i  in  6  hardware interrupt lines, level-sensitive.
- excepttype_i  in  32  raw MEM-stage flags: bit8 syscall, bit9 inst-invalid, bit10 trap, bit11 overflow, bit12 eret.
- current_inst_address_i  in  32  PC of the MEM-stage instruction; 0 = bubble.
- is_in_delayslot_i  in  1  MEM instruction is in a delay slot.
- wb_cp0_we_i  in  1  CP0 write enable from WB.
- wb_cp0_waddr_i  in  5  CP0 write address.
- wb_cp0_data_i  in  32  CP0 write data.
- raddr_i  in  5  CP0 read address (from EX).
- data_o  out  32  CP0 read data, combinational.
- excepttype_o  out  32  resolved code to the controller.
- cp0_epc_o  out  32  EPC forwarded to the controller.
- timer_int_o  out  1  timer interrupt, wired externally onto int_i[5].

Behaviour:
- Reset (rst=0, async):
  - Count, Compare, Cause, EPC = 0; Status = STATUS_RESET; timer_int_o = 0.
  - excepttype_o = 0 and cp0_epc_o = 0 while reset is asserted.
- Register addresses: Count 9, Compare 11, Status 12, Cause 13, EPC 14, PRId 15, Config 16.
  - Reads of other addresses return 0.
  - Writes to PRId, Config or unknown addresses are ignored.
- Count:
  - Increments by 1 every clock with 32-bit wrap.
  - A Count write takes precedence over the increment that cycle.
- Timer:
  - timer_int_o is set in the cycle after Count==Compare, provided Compare!=0.
  - Any Compare write clears timer_int_o.
  - Set and clear in the same cycle: clear wins.
- Cause:
  - IP[7:2] (bits 15:10) is loaded from int_i every clock.
  - Software-writable bits are IP[1:0] (9:8), IV (23) and WP (22) only.
- Forwarding: the Status, Cause and EPC values used for the interrupt check and for cp0_epc_o are the WB write data when WB writes that address this cycle, otherwise the register value.
- Resolution (combinational), skipped entirely when current_inst_address_i == 0:
  - Interrupt (code 32'h1) requires (Cause.IP & Status.IM) != 0, Status.EXL=0 and Status.IE=1.
  - Otherwise the first set flag in this order: bit8 -> 32'h8, bit9 -> 32'ha, bit10 -> 32'hd, bit11 -> 32'hc, bit12 -> 32'he.
  - No flag set -> 0.
- Exception entry (clock edge with excepttype_o in {1, 8, a, d, c}):
  - EPC = is_in_delayslot_i ? address-4 : address; Cause.BD = is_in_delayslot_i.
  - The EPC and BD updates happen only when Status.EXL was 0; nested entry keeps the original EPC and BD.
  - Status.EXL = 1.
  - Cause.ExcCode (6:2) = 0x00 for interrupt, 0x08 syscall, 0x0a RI, 0x0d trap, 0x0c Ov.
- ERET (excepttype_o = 32'he): Status.EXL is cleared at the clock edge.
- Simultaneous WB write and exception/ERET:
  - The WB write is applied first; exception-entry or ERET fields then override the same bits.
  - The WB instruction is older and the MEM instruction is then flushed.
- data_o: combinational read of the register value, with the same WB forwarding applied.

Decomposition:
- Shared defines hold:
  - CP0 register addresses.
  - Resolved excepttype codes 1/8/a/d/c/e.
  - ExcCode values.
  - Status/Cause bit positions (IE 0, EXL 1, IM 15:8, IP 15:8, BD 31, ExcCode 6:2).
- Natural sub-module: cp0_timer, holding Count, Compare and the timer_int_o flop.

Test Plan:
- Reset mid-run:
  - Stimulus: drive rst=0 asynchronously while Count=0x1234.
  - Required: all state and outputs clear immediately; Status=0x10000000.
- Syscall in a delay slot:
  - Stimulus: excepttype_i bit8 set, address 0x104, delayslot=1.
  - Required: excepttype_o=0x8; next cycle EPC=0x100, Cause.BD=1, ExcCode=0x08, EXL=1.
- Interrupt gating:
  - Stimulus: Status=0x0000_0401, int_i[0]=1, address 0x200.
  - Required: excepttype_o=0x1 and EPC=0x200. With EXL=1, or with address 0, excepttype_o=0.
- Priority:
  - Stimulus: bits 9 and 11 set together.
  - Required: excepttype_o=0xa. Adding bit8 gives 0x8.
- ERET with a same-cycle EPC write:
  - Stimulus: WB writes EPC=0x3000 while MEM holds eret.
  - Required: cp0_epc_o=0x3000 that cycle; EXL cleared next cycle.
- Timer:
  - Stimulus: Compare=5, Count reaches 5.
  - Required: timer_int_o=1 one cycle later; a Compare write clears it the following cycle.
